// File: rtl/adder_share_arbiter.sv
// Shares one external combinational adder among NREQ requesters.
// Round-robin grant, valid/ready on both sides, one operation in flight.
//
// state | meaning
// IDLE  | waiting for a request; grants the round-robin winner
// BUSY  | latched operands drive the adder; result captured at the edge
// DONE  | result held on resp_y until the granted requester takes it
module adder_share_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]      resp_y,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic [WIDTH-1:0]      add_y
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gnt;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [PTR_W-1:0]   winner;
  logic               found;
  int                 idx;

  // Round-robin search: scan offsets from the far end down so the
  // index closest to rr_ptr (wrapping) is the last one written.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

  // Next-state logic and the one-hot handshake outputs.
  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    resp_valid = '0;
    case (state)
      IDLE: begin
        if (found) begin
          req_ready = NREQ'(1) << winner;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        state_nxt = DONE;
      end
      DONE: begin
        resp_valid = NREQ'(1) << gnt;
        if (resp_ready[gnt]) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Adder operands come straight from registers so they never glitch.
  assign add_a = op_a;
  assign add_b = op_b;

  // State, pointer, operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      gnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      resp_y <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (found) begin
            op_a   <= req_a[int'(winner)*WIDTH +: WIDTH];
            op_b   <= req_b[int'(winner)*WIDTH +: WIDTH];
            gnt    <= winner;
            rr_ptr <= (winner == PTR_W'(NREQ - 1)) ? '0 : winner + PTR_W'(1);
          end
        end
        BUSY: begin
          resp_y <= add_y;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with a behavioural shared adder.
module tb_adder_share_arbiter;

  localparam int WIDTH = 16;
  localparam int NREQ  = 3;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       resp_valid;
  logic [NREQ-1:0]       resp_ready;
  logic [WIDTH-1:0]      resp_y;
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic [WIDTH-1:0]      add_y;

  int checks   = 0;
  int failures = 0;

  adder_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_y     (resp_y),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_y      (add_y)
  );

  // The shared adder itself: plain modular sum.
  assign add_y = add_a + add_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = '0;
    #2;
    check_eq("rst_req_ready", 32'(req_ready), 32'h0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'h0);
    check_eq("rst_resp_y", 32'(resp_y), 32'h0);
    check_eq("rst_add_a", 32'(add_a), 32'h0);
    check_eq("rst_add_b", 32'(add_b), 32'h0);
    do_reset();
    check_eq("idle_no_req", 32'(req_ready), 32'h0);

    // 1) requester 0: 1000 + 333
    set_op(0, 16'd1000, 16'd333);
    req_valid  = 3'b001;
    resp_ready = 3'b001;
    #1;
    check_eq("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #1;
    check_eq("t1_busy_ready", 32'(req_ready), 32'h0);
    check_eq("t1_busy_rv", 32'(resp_valid), 32'h0);
    check_eq("t1_add_a", 32'(add_a), 32'd1000);
    check_eq("t1_add_b", 32'(add_b), 32'd333);
    tick();
    check_eq("t1_resp_valid", 32'(resp_valid), 32'h1);
    check_eq("t1_resp_y", 32'(resp_y), 32'd1333);
    tick();
    check_eq("t1_back_idle", 32'(resp_valid), 32'h0);

    // 2) requester 1: wraparound sum
    set_op(1, 16'hFFFF, 16'h0001);
    req_valid  = 3'b010;
    resp_ready = 3'b010;
    #1;
    check_eq("t2_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick();
    check_eq("t2_resp_valid", 32'(resp_valid), 32'h2);
    check_eq("t2_resp_y", 32'(resp_y), 32'h0000);
    tick();

    // 3) all three held, pointer restarted at 0
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 16'(i), 16'd10);
    req_valid  = 3'b111;
    resp_ready = 3'b111;
    for (int g = 0; g < NREQ; g++) begin
      #1;
      check_eq($sformatf("t3_ready_%0d", g), 32'(req_ready), 32'(1 << g));
      tick();
      req_valid[g] = 1'b0;
      tick();
      check_eq($sformatf("t3_rv_%0d", g), 32'(resp_valid), 32'(1 << g));
      check_eq($sformatf("t3_y_%0d", g), 32'(resp_y), 32'(10 + g));
      check_eq($sformatf("t3_excl_%0d", g), 32'(req_ready), 32'h0);
      tick();
    end

    // 4) requester 2 result held while resp_ready[2] low; others ignored
    set_op(2, 16'd250, 16'd1500);
    req_valid  = 3'b100;
    resp_ready = 3'b000;
    #1;
    check_eq("t4_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    tick();
    set_op(0, 16'd7, 16'd8);
    req_valid  = 3'b001;
    resp_ready = 3'b011;
    for (int c = 0; c < 5; c++) begin
      #1;
      check_eq($sformatf("t4_hold_rv_%0d", c), 32'(resp_valid), 32'h4);
      check_eq($sformatf("t4_hold_y_%0d", c), 32'(resp_y), 32'd1750);
      check_eq($sformatf("t4_hold_rr_%0d", c), 32'(req_ready), 32'h0);
      tick();
    end
    resp_ready = 3'b100;
    tick();
    check_eq("t4_next_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid  = '0;
    resp_ready = 3'b111;
    tick();
    check_eq("t4_next_y", 32'(resp_y), 32'd15);
    check_eq("t4_next_rv", 32'(resp_valid), 32'h1);
    tick();

    // 5) grant 1, then 0 and 2 pending: 2 first, then wrap to 0
    set_op(1, 16'd5, 16'd5);
    req_valid = 3'b010;
    #1;
    check_eq("t5_g1_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick();
    tick();
    set_op(0, 16'd100, 16'd1);
    set_op(2, 16'd200, 16'd2);
    req_valid = 3'b101;
    #1;
    check_eq("t5_g2_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid[2] = 1'b0;
    tick();
    check_eq("t5_g2_rv", 32'(resp_valid), 32'h4);
    check_eq("t5_g2_y", 32'(resp_y), 32'd202);
    tick();
    check_eq("t5_g0_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick();
    check_eq("t5_g0_rv", 32'(resp_valid), 32'h1);
    check_eq("t5_g0_y", 32'(resp_y), 32'd101);
    tick();

    // 6) async reset mid-BUSY; pointer returns to 0 (rr_ptr is 1 beforehand)
    set_op(0, 16'd3, 16'd4);
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    #1;
    check_eq("t6_busy_add_a", 32'(add_a), 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_add_a", 32'(add_a), 32'h0);
    check_eq("t6_rst_add_b", 32'(add_b), 32'h0);
    check_eq("t6_rst_y", 32'(resp_y), 32'h0);
    check_eq("t6_rst_rv", 32'(resp_valid), 32'h0);
    check_eq("t6_rst_rr", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    set_op(0, 16'd20, 16'd22);
    set_op(2, 16'd9, 16'd9);
    req_valid = 3'b101;
    #1;
    check_eq("t6_ptr0_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid[0] = 1'b0;
    tick();
    check_eq("t6_y", 32'(resp_y), 32'd42);
    tick();
    check_eq("t6_then2", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    tick();
    check_eq("t6_y2", 32'(resp_y), 32'd18);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
